// File: rtl/mem_interface.sv
// mem_interface: single-port CPU-to-RAM transfer controller.
//
// Accepts one load/store request at a time from the CPU, strobes the RAM,
// waits WAIT_STATES idle cycles, then pulses done (with err for an
// out-of-range address) and returns load data on rdata.
//
// Optional feature: define MEMIF_WRITE_VERIFY_EN to read back every store
// through an extra VERIFY cycle and raise the sticky verify_err flag on a
// read-back mismatch. Without it, verify_err is tied low.
//
// Parameters:
//   WAIT_STATES  extra idle cycles between strobe and completion (0-7)
//   ADDR_LIMIT   highest legal word address
// Ports:
//   clock, clear_n       clock (rising edge), async active-low reset
//   req, we, addr, wdata CPU request, sampled when req & ready
//   ready, done, err     handshake / one-cycle completion / range error
//   rdata                last load result
//   ram_address, ram_in  RAM address and write data (held for the transfer)
//   ram_write_en/read_en RAM strobes, never both high
//   ram_out              RAM read data, registered one edge after read_en
//   verify_err           sticky write-verify mismatch flag

module mem_interface #(
    parameter int WAIT_STATES = 0,
    parameter int ADDR_LIMIT  = 511
) (
    input  logic        clock,
    input  logic        clear_n,
    input  logic        req,
    input  logic        we,
    input  logic [8:0]  addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [8:0]  ram_address,
    output logic [31:0] ram_in,
    output logic        ram_write_en,
    output logic        ram_read_en,
    input  logic [31:0] ram_out,
    output logic        verify_err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ISSUE    = 3'd1;
    localparam logic [2:0] WAIT     = 3'd2;
`ifdef MEMIF_WRITE_VERIFY_EN
    localparam logic [2:0] VERIFY   = 3'd3;
`endif
    localparam logic [2:0] COMPLETE = 3'd4;

    localparam logic [2:0] WS    = 3'(WAIT_STATES);
    // One bit wider than addr so a limit of 511 (or above) never truncates.
    localparam logic [9:0] LIMIT = 10'(ADDR_LIMIT);

    // Request captured at accept; drives the RAM for the whole transfer.
    typedef struct packed {
        logic        we;
        logic        oor;    // address beyond ADDR_LIMIT: no RAM access
        logic [8:0]  addr;
        logic [31:0] wdata;
    } req_t;

    logic [2:0] state, state_nxt, post_issue;
    logic [2:0] cnt;
    req_t       lat;
    logic       accept, oor_in, vfy_rd;

    assign ready  = (state == IDLE);
    assign accept = req & ready;
    assign oor_in = ({1'b0, addr} > LIMIT);

    // Where a transfer goes once its strobe (and any wait states) are done.
`ifdef MEMIF_WRITE_VERIFY_EN
    assign post_issue = lat.we ? VERIFY : COMPLETE;
    assign vfy_rd     = (state == VERIFY);
`else
    assign post_issue = COMPLETE;
    assign vfy_rd     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (accept) state_nxt = oor_in ? COMPLETE : ISSUE;
            ISSUE:    state_nxt = (WS != 3'd0) ? WAIT : post_issue;
            WAIT:     if (cnt == 3'd0) state_nxt = post_issue;
`ifdef MEMIF_WRITE_VERIFY_EN
            VERIFY:   state_nxt = COMPLETE;
`endif
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // cnt is loaded with WS-1 on the way into WAIT so WAIT lasts exactly WS cycles.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == ISSUE)
                cnt <= WS - 3'd1;
            else if (state == WAIT)
                cnt <= cnt - 3'd1;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            lat <= '0;
        else if (accept)
            lat <= '{we: we, oor: oor_in, addr: addr, wdata: wdata};
    end

    // Strobes decode straight from the state register so reset drops them
    // asynchronously along with the state.
    assign ram_address  = lat.addr;
    assign ram_in       = lat.wdata;
    assign ram_write_en = (state == ISSUE) &  lat.we;
    assign ram_read_en  = ((state == ISSUE) & ~lat.we) | vfy_rd;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            done <= (state == COMPLETE);
            err  <= (state == COMPLETE) & lat.oor;
            if ((state == COMPLETE) && !lat.we && !lat.oor)
                rdata <= ram_out;
        end
    end

`ifdef MEMIF_WRITE_VERIFY_EN
    // ram_out holds the VERIFY read-back during COMPLETE.
    logic vfy_q;
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n)
            vfy_q <= 1'b0;
        else if ((state == COMPLETE) && lat.we && !lat.oor && (ram_out != lat.wdata))
            vfy_q <= 1'b1;
    end
    assign verify_err = vfy_q;
`else
    assign verify_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_interface.sv
// Scoreboard bench for mem_interface: two instances (WAIT_STATES=0 with
// ADDR_LIMIT=255, and WAIT_STATES=3 with ADDR_LIMIT=511), each with a small
// RAM model. Drivers push expected completions; negedge monitors pop them.

module tb_mem_interface;

`ifdef MEMIF_WRITE_VERIFY_EN
    localparam int V = 1;
`else
    localparam int V = 0;
`endif

    typedef struct {
        int          acc;
        int          lat;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    logic clock, clear_n;
    int   cyc;
    int   pass_cnt, total_cnt;

    // DUT 0 : WAIT_STATES=0, ADDR_LIMIT=255
    logic        req0, we0, ready0, done0, err0, wen0, ren0, verr0;
    logic [8:0]  addr0, raddr0;
    logic [31:0] wdata0, rdata0, rin0, rout0;
    // DUT 3 : WAIT_STATES=3, ADDR_LIMIT=511
    logic        req3, we3, ready3, done3, err3, wen3, ren3, verr3;
    logic [8:0]  addr3, raddr3;
    logic [31:0] wdata3, rdata3, rin3, rout3;

    exp_t q0[$], q3[$];
    int   acc_log[$];
    exp_t m0, m3;

    mem_interface #(.WAIT_STATES(0), .ADDR_LIMIT(255)) u_dut0 (
        .clock(clock), .clear_n(clear_n), .req(req0), .we(we0), .addr(addr0),
        .wdata(wdata0), .ready(ready0), .done(done0), .err(err0), .rdata(rdata0),
        .ram_address(raddr0), .ram_in(rin0), .ram_write_en(wen0), .ram_read_en(ren0),
        .ram_out(rout0), .verify_err(verr0));

    mem_interface #(.WAIT_STATES(3), .ADDR_LIMIT(511)) u_dut3 (
        .clock(clock), .clear_n(clear_n), .req(req3), .we(we3), .addr(addr3),
        .wdata(wdata3), .ready(ready3), .done(done3), .err(err3), .rdata(rdata3),
        .ram_address(raddr3), .ram_in(rin3), .ram_write_en(wen3), .ram_read_en(ren3),
        .ram_out(rout3), .verify_err(verr3));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // RAM models; unwritten words read as a fixed address-derived pattern.
    logic [31:0] mem0 [0:511];
    logic [31:0] mem3 [0:511];
    bit          vld0 [0:511];
    bit          vld3 [0:511];
    bit          corrupt;

    always @(posedge clock) begin
        if (wen0) begin
            mem0[raddr0] <= corrupt ? (rin0 ^ 32'h1) : rin0;
            vld0[raddr0] <= 1'b1;
        end
        if (ren0) rout0 <= vld0[raddr0] ? mem0[raddr0] : (32'h1000_0000 + {23'd0, raddr0});
        if (wen3) begin
            mem3[raddr3] <= rin3;
            vld3[raddr3] <= 1'b1;
        end
        if (ren3) rout3 <= vld3[raddr3] ? mem3[raddr3] : (32'hC0DE_0000 + {23'd0, raddr3});
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // Strobe / done counters (cumulative; drivers compare snapshots).
    int wr_cnt0, rd_cnt0, done_cnt0, both_cnt0, rd_cnt3;
    logic [8:0]  last_wa0;
    logic [31:0] last_wd0;
    initial begin
        wr_cnt0 = 0; rd_cnt0 = 0; done_cnt0 = 0; both_cnt0 = 0; rd_cnt3 = 0;
    end

    always @(negedge clock) begin
        if (wen0) begin
            wr_cnt0  <= wr_cnt0 + 1;
            last_wa0 <= raddr0;
            last_wd0 <= rin0;
        end
        if (ren0) rd_cnt0 <= rd_cnt0 + 1;
        if (wen0 && ren0) both_cnt0 <= both_cnt0 + 1;
        if (ren3 || wen3) rd_cnt3 <= rd_cnt3 + 1;
        if (done0) done_cnt0 <= done_cnt0 + 1;
    end

    // Scoreboard monitors
    always @(negedge clock) begin
        if (done0) begin
            if (q0.size() == 0) chk1("unexpected_done0", done0, 1'b0);
            else begin
                m0 = q0.pop_front();
                chk("latency0", cyc - m0.acc, m0.lat);
                chk1("err0", err0, m0.err);
                chk("rdata0", rdata0, m0.rdata);
            end
        end
    end

    always @(negedge clock) begin
        if (done3) begin
            if (q3.size() == 0) chk1("unexpected_done3", done3, 1'b0);
            else begin
                m3 = q3.pop_front();
                chk("latency3", cyc - m3.acc, m3.lat);
                chk1("err3", err3, m3.err);
                chk("rdata3", rdata3, m3.rdata);
            end
        end
    end

    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic txn0(input logic w, input logic [8:0] a, input logic [31:0] d,
                        input int lat, input logic e, input logic [31:0] rd,
                        input bit push, input bit keep);
        exp_t x;
        int   n;
        req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
        n = 0;
        while (!ready0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!ready0) begin
            chk1("accept_timeout0", ready0, 1'b1);
            req0 = 1'b0;
            return;
        end
        x.acc = cyc + 1; x.lat = lat; x.err = e; x.rdata = rd;
        if (push) q0.push_back(x);
        acc_log.push_back(x.acc);
        @(posedge clock);
        @(negedge clock);
        if (!keep) req0 = 1'b0;
    endtask

    task automatic txn3(input logic w, input logic [8:0] a, input logic [31:0] d,
                        input int lat, input logic [31:0] rd);
        exp_t x;
        int   n;
        req3 = 1'b1; we3 = w; addr3 = a; wdata3 = d;
        n = 0;
        while (!ready3 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!ready3) begin
            chk1("accept_timeout3", ready3, 1'b1);
            req3 = 1'b0;
            return;
        end
        x.acc = cyc + 1; x.lat = lat; x.err = 1'b0; x.rdata = rd;
        q3.push_back(x);
        @(posedge clock);
        @(negedge clock);
        req3 = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q0.size() != 0 || q3.size() != 0) && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({nm, "_pending"}, q0.size() + q3.size(), 0);
        @(negedge clock);
    endtask

    int s_wr, s_rd, s_dn, s_r3;

    initial begin
        corrupt = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req3 = 0; we3 = 0; addr3 = '0; wdata3 = '0;
        pass_cnt = 0; total_cnt = 0;
        clear_n = 1'b0;
        repeat (2) @(negedge clock);

        // Reset state
        chk1("rst_ready", ready0, 1'b1);
        chk1("rst_done", done0, 1'b0);
        chk1("rst_err", err0, 1'b0);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_ram_address", {23'd0, raddr0}, 32'h0);
        chk("rst_ram_in", rin0, 32'h0);
        chk1("rst_wen", wen0, 1'b0);
        chk1("rst_ren", ren0, 1'b0);
        chk1("rst_verify_err", verr0, 1'b0);

        // Store right at reset release: accepted on the first edge
        clear_n = 1'b1;
        s_wr = wr_cnt0; s_rd = rd_cnt0;
        txn0(1'b1, 9'h08E, 32'h0000_00AB, 2 + V, 1'b0, 32'h0, 1'b1, 1'b0);
        drain("store");
        chk("store_wr_strobes", wr_cnt0 - s_wr, 1);
        chk("store_rd_strobes", rd_cnt0 - s_rd, V);
        chk("store_wr_addr", {23'd0, last_wa0}, 32'h8E);
        chk("store_wr_data", last_wd0, 32'h0000_00AB);

        // Load back
        s_wr = wr_cnt0; s_rd = rd_cnt0;
        txn0(1'b0, 9'h08E, 32'h0, 2, 1'b0, 32'h0000_00AB, 1'b1, 1'b0);
        drain("load");
        chk("load_rd_strobes", rd_cnt0 - s_rd, 1);
        chk("load_wr_strobes", wr_cnt0 - s_wr, 0);

        // Out of range (limit 255): no strobe, err, rdata kept
        s_wr = wr_cnt0; s_rd = rd_cnt0;
        txn0(1'b0, 9'h100, 32'h0, 1, 1'b1, 32'h0000_00AB, 1'b1, 1'b0);
        drain("oor");
        chk("oor_strobes", (wr_cnt0 - s_wr) + (rd_cnt0 - s_rd), 0);

        // req held high for four loads
        s_dn = done_cnt0;
        acc_log.delete();
        txn0(1'b0, 9'h010, 32'h0, 2, 1'b0, 32'h1000_0010, 1'b1, 1'b1);
        txn0(1'b0, 9'h011, 32'h0, 2, 1'b0, 32'h1000_0011, 1'b1, 1'b1);
        txn0(1'b0, 9'h012, 32'h0, 2, 1'b0, 32'h1000_0012, 1'b1, 1'b1);
        txn0(1'b0, 9'h013, 32'h0, 2, 1'b0, 32'h1000_0013, 1'b1, 1'b0);
        drain("b2b");
        repeat (3) @(negedge clock);
        chk("b2b_done_count", done_cnt0 - s_dn, 4);
        for (int i = 1; i < 4; i++)
            chk("b2b_spacing", acc_log[i] - acc_log[i-1], 3);

        // Three wait states
        s_r3 = rd_cnt3;
        txn3(1'b0, 9'h047, 32'h0, 5, 32'hC0DE_0047);
        drain("ws3");
        chk("ws3_strobes", rd_cnt3 - s_r3, 1);

`ifdef MEMIF_WRITE_VERIFY_EN
        corrupt = 1'b1;
        txn0(1'b1, 9'h020, 32'h5A5A_5A5A, 3, 1'b0, 32'h1000_0013, 1'b1, 1'b0);
        drain("vfy_bad");
        corrupt = 1'b0;
        chk1("verify_err_set", verr0, 1'b1);
        txn0(1'b1, 9'h021, 32'h1234_5678, 3, 1'b0, 32'h1000_0013, 1'b1, 1'b0);
        drain("vfy_good");
        chk1("verify_err_sticky", verr0, 1'b1);
`else
        txn0(1'b1, 9'h020, 32'h5A5A_5A5A, 2, 1'b0, 32'h1000_0013, 1'b1, 1'b0);
        drain("st2");
        chk1("verify_err_tied", verr0, 1'b0);
        txn0(1'b0, 9'h020, 32'h0, 2, 1'b0, 32'h5A5A_5A5A, 1'b1, 1'b0);
        drain("ld2");
`endif

        // Reset during ISSUE: strobe drops at once, no done
        s_dn = done_cnt0;
        txn0(1'b0, 9'h08E, 32'h0, 2, 1'b0, 32'h0, 1'b0, 1'b0);
        chk1("abort_issue_strobe", ren0, 1'b1);
        #1 clear_n = 1'b0;
        #1;
        chk1("abort_strobe_async", ren0, 1'b0);
        chk1("abort_ready_async", ready0, 1'b1);
        repeat (2) @(negedge clock);
        chk("abort_rdata", rdata0, 32'h0);
        chk("abort_ram_address", {23'd0, raddr0}, 32'h0);
        chk1("abort_verify_err", verr0, 1'b0);
        clear_n = 1'b1;
        repeat (4) @(negedge clock);
        chk("abort_no_done", done_cnt0 - s_dn, 0);
        txn0(1'b0, 9'h08E, 32'h0, 2, 1'b0, 32'h0000_00AB, 1'b1, 1'b0);
        drain("post_reset");

        chk("strobes_both_high", both_cnt0, 0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/mem_interface.md
MEM_INTERFACE -- requirements
Module: mem_interface

Interface
REQ-001 SHALL have parameter WAIT_STATES, default 0, giving extra idle cycles (0-7) between RAM strobe and completion.
REQ-002 SHALL have parameter ADDR_LIMIT, default 511, giving the highest legal word address.
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port clear_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port req, input, 1, CPU transfer request.
REQ-006 SHALL have port we, input, 1, 1=store and 0=load, sampled with req.
REQ-007 SHALL have port addr, input, 9, word address, sampled with req.
REQ-008 SHALL have port wdata, input, 32, store data, sampled with req.
REQ-009 SHALL have port ready, output, 1, high when a request can be accepted.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1, valid with done; 1 = address out of range.
REQ-012 SHALL have port rdata, output, 32, load result, valid from the done cycle until the next load completes.
REQ-013 SHALL have port ram_address, output, 9, address to the RAM.
REQ-014 SHALL have port ram_in, output, 32, write data to the RAM.
REQ-015 SHALL have port ram_write_en, output, 1, RAM write strobe.
REQ-016 SHALL have port ram_read_en, output, 1, RAM read strobe.
REQ-017 SHALL have port ram_out, input, 32, RAM read data, registered by the RAM one edge after ram_read_en is sampled.
REQ-018 SHALL have port verify_err, output, 1, sticky write-verify mismatch flag.

Function
REQ-019 SHALL use states IDLE, ISSUE, WAIT, VERIFY, COMPLETE; ready=1 only in IDLE.
REQ-020 SHALL accept a request on an edge where req=1 and ready=1, latching we, addr and wdata into internal registers; req with ready=0 SHALL be ignored and not queued.
REQ-021 SHALL, on accept with addr<=ADDR_LIMIT, go IDLE->ISSUE; with addr>ADDR_LIMIT, go IDLE->COMPLETE with no RAM strobe and flag err.
REQ-022 SHALL assert exactly one strobe (ram_write_en if we, else ram_read_en) for the single ISSUE cycle; the two strobes SHALL never be high together.
REQ-023 SHALL hold ram_address and ram_in at the latched values from ISSUE through COMPLETE.
REQ-024 SHALL go ISSUE->WAIT when WAIT_STATES>0 and stay in WAIT for exactly WAIT_STATES cycles (3-bit down-counter); otherwise ISSUE->COMPLETE (or VERIFY, REQ-033).
REQ-025 SHALL, on the edge leaving COMPLETE, return to IDLE, pulse done=1 for one cycle, set err, and for loads load rdata<=ram_out.
REQ-026 SHALL give, with WAIT_STATES=0: accept edge E, ISSUE in cycle E+1, COMPLETE in E+2, done/ready/rdata valid in E+3; each wait state adds one cycle.
REQ-027 SHALL allow back-to-back transfers: a req held high is accepted at the end of the done cycle.
REQ-028 SHALL leave rdata unchanged on stores and on err completions.

Reset
REQ-029 SHALL, while clear_n=0, force IDLE immediately, with ready=1, done=0, err=0, verify_err=0, rdata=0, ram_address=0, ram_in=0, ram_write_en=0 and ram_read_en=0.
REQ-030 SHALL abort any in-flight transfer on reset without producing done; a strobe in progress SHALL drop asynchronously.
REQ-031 SHALL accept its first request at the first rising edge after clear_n deasserts.

Configuration
REQ-032 SHALL use macro MEMIF_WRITE_VERIFY_EN.
REQ-033 With MEMIF_WRITE_VERIFY_EN defined, a store SHALL pass through VERIFY after ISSUE/WAIT.
REQ-034 In VERIFY, ram_read_en=1 for one cycle; in COMPLETE, ram_out SHALL be compared to the latched wdata.
REQ-035 On a mismatch, verify_err SHALL be set and held until reset.
REQ-036 With MEMIF_WRITE_VERIFY_EN defined, store latency SHALL increase by one cycle.
REQ-037 Without MEMIF_WRITE_VERIFY_EN, VERIFY SHALL be absent and verify_err SHALL be tied to 0.

Verification
REQ-038 Store addr=0x8E, wdata=0x0000_00AB, WAIT_STATES=0 -> ram_write_en high one cycle at 0x8E, done at E+3, err=0.
REQ-039 Then load addr=0x8E -> ram_read_en one cycle, done at E+3, rdata=0x0000_00AB.
REQ-040 WAIT_STATES=3 load addr=0x47 -> done at E+6 with the RAM contents of 0x47.
REQ-041 ADDR_LIMIT=255, load addr=0x100 -> no strobe, done+err=1 at E+2, rdata unchanged.
REQ-042 req held high for 4 loads -> accepts spaced 3 cycles apart, exactly 4 done pulses.
REQ-043 clear_n low during ISSUE -> strobe drops immediately, no done; with MEMIF_WRITE_VERIFY_EN and a RAM model forced to corrupt one write -> verify_err=1 and sticky.
